// File: rtl/regfile_2r1w_if.sv
// rtl/regfile_2r1w_if.sv - write/read bus of the 2-read 1-write register file
interface regfile_2r1w_if #(
    parameter int K  = 16,
    parameter int AW = 3
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [K-1:0]  wdata;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic          hold;
    logic [K-1:0]  rdata_a;
    logic [K-1:0]  rdata_b;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, hold,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, hold,
        output rdata_a, rdata_b
    );
endinterface

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - NREGS x K register file, two read ports, one write port
module regfile_2r1w #(
    parameter int K       = 16,
    parameter int NREGS   = 8,
    parameter int AW      = $clog2(NREGS),
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0,
    parameter int OUT_REG = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_2r1w_if.slave  rf
);
    logic [K-1:0]  mem_q [NREGS];
    logic          wr_ok;
    logic [AW-1:0] raddr [2];
    logic [K-1:0]  rv_d  [2];

    assign raddr[0] = rf.raddr_a;
    assign raddr[1] = rf.raddr_b;

    // A write is effective only in range and, with a hardwired r0, not to address 0
    always_comb begin
        wr_ok = rf.we && (int'(rf.waddr) < NREGS);
        if (R0_ZERO != 0 && rf.waddr == '0) begin
            wr_ok = 1'b0;
        end
    end

    // Storage array; reset clears every word at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[rf.waddr] <= rf.wdata;
        end
    end

    // Read value per port: out-of-range and r0 read as zero, then bypass, then storage
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rv_d[p] = '0;
            if (int'(raddr[p]) >= NREGS) begin
                rv_d[p] = '0;
            end else if (R0_ZERO != 0 && raddr[p] == '0) begin
                rv_d[p] = '0;
            end else if (BYPASS != 0 && wr_ok && raddr[p] == rf.waddr) begin
                rv_d[p] = rf.wdata;
            end else begin
                rv_d[p] = mem_q[raddr[p]];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [K-1:0] rdata_a_q;
            logic [K-1:0] rdata_b_q;

            // Registered read stage; hold freezes both ports while writes continue
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_a_q <= '0;
                    rdata_b_q <= '0;
                end else if (!rf.hold) begin
                    rdata_a_q <= rv_d[0];
                    rdata_b_q <= rv_d[1];
                end
            end

            assign rf.rdata_a = rdata_a_q;
            assign rf.rdata_b = rdata_b_q;
        end else begin : g_comb
            logic unused_hold;
            assign unused_hold = rf.hold;
            assign rf.rdata_a  = rv_d[0];
            assign rf.rdata_b  = rv_d[1];
        end
    endgenerate
endmodule
